// File: rtl/cap_touch_scanner.sv
// rtl/cap_touch_scanner.sv - shared-charge-line capacitive pad scanner with debounced touch mask
module cap_touch_scanner #(
    parameter int N_SENSORS        = 9,
    parameter int CNT_W            = 16,
    parameter int DISCHARGE_CYCLES = 1000,
    parameter int CHARGE_TIMEOUT   = 4000,
    parameter int TOUCH_THRESH     = 600,
    parameter int DEBOUNCE         = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] capacitive_sensors_in,
    output logic                 capacitive_sensors_out,
    output logic [N_SENSORS-1:0] touch_mask,
    output logic                 touch_valid,
    output logic                 scan_busy
);

    localparam int AW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] DIS_LAST = CNT_W'(DISCHARGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHG_LAST = CNT_W'(CHARGE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CHG_MAX  = CNT_W'(CHARGE_TIMEOUT);
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(TOUCH_THRESH);
    localparam logic [AW-1:0]    DEB_LAST = AW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {S_IDLE, S_DISCHARGE, S_CHARGE, S_EVAL} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [N_SENSORS-1:0] sync1_q, sync_q;
    logic [N_SENSORS-1:0] done_q;
    logic [CNT_W-1:0]     count_q [N_SENSORS];
    logic [AW-1:0]        agree_q [N_SENSORS];
    logic [N_SENSORS-1:0] mask_q;
    logic                 valid_q;
    logic [N_SENSORS-1:0] raw;
    logic                 all_done;
    logic                 start_charge;
    logic                 timeout;

    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    // Pads rising in this very cycle count as done so the phase ends without an idle cycle.
    assign all_done = &(done_q | sync_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        start_charge = 1'b0;
        timeout      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_DISCHARGE;
                    cnt_d   = '0;
                end
            end
            S_DISCHARGE: begin
                cnt_d = cnt_inc;
                if (cnt_q == DIS_LAST) begin
                    state_d      = S_CHARGE;
                    cnt_d        = '0;
                    start_charge = 1'b1;
                end
            end
            S_CHARGE: begin
                cnt_d   = cnt_inc;
                timeout = (cnt_q == CHG_LAST);
                if (all_done || timeout) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                cnt_d   = '0;
                state_d = enable ? S_DISCHARGE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            raw[i] = (count_q[i] >= THRESH);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync_q  <= '0;
            done_q  <= '0;
            mask_q  <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < N_SENSORS; i++) begin
                count_q[i] <= '0;
                agree_q[i] <= '0;
            end
        end else begin
            sync1_q <= capacitive_sensors_in;
            sync_q  <= sync1_q;
            valid_q <= (state_q == S_EVAL);
            if (start_charge) begin
                done_q <= '0;
                for (int i = 0; i < N_SENSORS; i++) begin
                    count_q[i] <= '0;
                end
            end else if (state_q == S_CHARGE) begin
                // A pad that never rises is pinned at the timeout value, which reads as a touch.
                for (int i = 0; i < N_SENSORS; i++) begin
                    if (!done_q[i]) begin
                        if (sync_q[i]) begin
                            count_q[i] <= cnt_q;
                            done_q[i]  <= 1'b1;
                        end else if (timeout) begin
                            count_q[i] <= CHG_MAX;
                            done_q[i]  <= 1'b1;
                        end
                    end
                end
            end
            if (state_q == S_EVAL) begin
                for (int i = 0; i < N_SENSORS; i++) begin
                    if (raw[i] != mask_q[i]) begin
                        if (agree_q[i] >= DEB_LAST) begin
                            mask_q[i]  <= raw[i];
                            agree_q[i] <= '0;
                        end else begin
                            agree_q[i] <= agree_q[i] + 1'b1;
                        end
                    end else begin
                        agree_q[i] <= '0;
                    end
                end
            end
        end
    end

    assign capacitive_sensors_out = (state_q == S_CHARGE);
    assign scan_busy              = (state_q != S_IDLE);
    assign touch_mask             = mask_q;
    assign touch_valid            = valid_q;

endmodule
